// File: rtl/window_addr_gen.sv
// Window address generator: NUM_COL column address channels advanced
// round-robin, with a periodic row advance that bumps columns 1..NUM_COL-1.
// Runs from Start until column 0 is written with a value equal to MaxAddr.
module window_addr_gen #(
    parameter int ADDR_W     = 8,
    parameter int NUM_COL    = 4,
    parameter int ROW_PERIOD = 61,
    parameter int C0_BASE    = 15,
    localparam int SEL_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic                        On,
    input  logic [ADDR_W-1:0]           MaxAddr,
    output logic [NUM_COL*ADDR_W-1:0]   Addr,
    output logic [SEL_W-1:0]            ColSel,
    output logic                        AddrValid,
    output logic                        RowAdv,
    output logic                        Busy,
    output logic                        Done
);

    localparam int RC_W = (ROW_PERIOD > 1) ? $clog2(ROW_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q [NUM_COL];
    logic [ADDR_W-1:0] addr_d [NUM_COL];
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;
    logic [RC_W-1:0]   row_q;
    logic [RC_W-1:0]   row_d;
    logic              row_wrap;
    logic              hit;
    logic              rowadv_q;
    logic              busy_q;
    logic              done_q;

    // Candidate next values for one enabled RUN cycle; a column that is both
    // selected and row-advanced picks up both increments (+2), modulo 2^ADDR_W.
    always_comb begin
        row_wrap = (row_q == RC_W'(ROW_PERIOD - 1));
        row_d    = row_wrap ? '0 : row_q + RC_W'(1);
        sel_d    = (sel_q == SEL_W'(NUM_COL - 1)) ? '0 : sel_q + SEL_W'(1);
        for (int k = 0; k < NUM_COL; k++) begin
            addr_d[k] = addr_q[k]
                      + ADDR_W'(sel_q == SEL_W'(k))
                      + ADDR_W'(row_wrap && (k != 0));
        end
        // Terminal check only on cycles that actually write column 0.
        hit = (sel_q == '0) && (addr_d[0] == MaxAddr);
    end

    // Control FSM with registered status outputs and the address state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            row_q    <= '0;
            rowadv_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int k = 0; k < NUM_COL; k++) begin
                addr_q[k] <= (k == 0) ? ADDR_W'(C0_BASE) : '0;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rowadv_q <= 1'b0;
                    if (Start) begin
                        state_q <= RUN;
                        sel_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        for (int k = 0; k < NUM_COL; k++) begin
                            addr_q[k] <= (k == 0) ? ADDR_W'(C0_BASE) : '0;
                        end
                    end
                end
                RUN: begin
                    if (On) begin
                        addr_q   <= addr_d;
                        sel_q    <= sel_d;
                        row_q    <= row_d;
                        rowadv_q <= row_wrap;
                        if (hit) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        rowadv_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rowadv_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the column registers onto the packed output bus.
    for (genvar g = 0; g < NUM_COL; g++) begin : g_addr_out
        assign Addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    assign ColSel    = sel_q;
    assign RowAdv    = rowadv_q;
    assign Busy      = busy_q;
    assign AddrValid = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: three instances (defaults, short row
// period, 4-bit addresses) share the control inputs.
module tb_window_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        on;

    logic [7:0]  max_def;
    logic [31:0] addr_def;
    logic [1:0]  sel_def;
    logic        av_def, ra_def, busy_def, done_def;

    logic [7:0]  max_rp6;
    logic [31:0] addr_rp6;
    logic [1:0]  sel_rp6;
    logic        av_rp6, ra_rp6, busy_rp6, done_rp6;

    logic [3:0]  max_a4;
    logic [15:0] addr_a4;
    logic [1:0]  sel_a4;
    logic        av_a4, ra_a4, busy_a4, done_a4;

    int errors = 0;
    int checks = 0;
    int ra_cnt;
    int ra_at;

    always #5 clk = ~clk;

    window_addr_gen u_def (
        .Clk(clk), .Rst(rst), .Start(start), .On(on), .MaxAddr(max_def),
        .Addr(addr_def), .ColSel(sel_def), .AddrValid(av_def),
        .RowAdv(ra_def), .Busy(busy_def), .Done(done_def)
    );

    window_addr_gen #(.ROW_PERIOD(6)) u_rp6 (
        .Clk(clk), .Rst(rst), .Start(start), .On(on), .MaxAddr(max_rp6),
        .Addr(addr_rp6), .ColSel(sel_rp6), .AddrValid(av_rp6),
        .RowAdv(ra_rp6), .Busy(busy_rp6), .Done(done_rp6)
    );

    window_addr_gen #(.ADDR_W(4), .C0_BASE(14)) u_a4 (
        .Clk(clk), .Rst(rst), .Start(start), .On(on), .MaxAddr(max_a4),
        .Addr(addr_a4), .ColSel(sel_a4), .AddrValid(av_a4),
        .RowAdv(ra_a4), .Busy(busy_a4), .Done(done_a4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_addr"},   addr_def, 32'h0000000F);
        chk({tag, "_sel"},    {30'd0, sel_def}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy_def}, 32'd0);
        chk({tag, "_done"},   {31'd0, done_def}, 32'd0);
        chk({tag, "_valid"},  {31'd0, av_def}, 32'd0);
        chk({tag, "_rowadv"}, {31'd0, ra_def}, 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b1;
        on      = 1'b1;
        max_def = 8'd200;
        max_rp6 = 8'd200;
        max_a4  = 4'd1;
        step();
        step();
        chk_reset("rst0");
        chk("rst0_a4_col0", {28'd0, addr_a4[3:0]}, 32'd14);

        // Launch; Start stays high through the first enabled cycles to show RUN ignores it.
        rst = 1'b0;
        on  = 1'b0;
        step();
        chk("launch_busy",  {31'd0, busy_def}, 32'd1);
        chk("launch_valid", {31'd0, av_def}, 32'd1);
        chk("launch_addr",  addr_def, 32'h0000000F);

        on     = 1'b1;
        ra_cnt = 0;
        ra_at  = 0;
        for (int n = 1; n <= 61; n++) begin
            if (n == 5) start = 1'b0;
            step();
            if (ra_def) begin
                ra_cnt++;
                ra_at = n;
            end
            if (n == 4) begin
                chk("four_addr",   addr_def, 32'h01010110);
                chk("four_sel",    {30'd0, sel_def}, 32'd0);
                chk("four_rowadv", ra_cnt, 32'd0);
            end
            if (n == 6) begin
                chk("rp6_addr",   addr_rp6, 32'h02020311);
                chk("rp6_rowadv", {31'd0, ra_rp6}, 32'd1);
            end
            if (n == 7) chk("rp6_rowadv_pulse", {31'd0, ra_rp6}, 32'd0);
            if (n == 1) chk("a4_col0_c1", {28'd0, addr_a4[3:0]}, 32'd15);
            if (n == 5) chk("a4_col0_c5", {28'd0, addr_a4[3:0]}, 32'd0);
            if (n == 8) chk("a4_done_c8", {31'd0, done_a4}, 32'd0);
            if (n == 9) begin
                chk("a4_col0_c9", {28'd0, addr_a4[3:0]}, 32'd1);
                chk("a4_done_c9", {31'd0, done_a4}, 32'd1);
            end
            if (n == 12) chk("a4_frozen", {28'd0, addr_a4[3:0]}, 32'd1);
        end
        chk("row_addr",        addr_def, 32'h1010101F);
        chk("row_rowadv_cnt",  ra_cnt, 32'd1);
        chk("row_rowadv_at",   ra_at, 32'd61);

        // Hold with On low: everything freezes and the row pulse drops.
        on = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("hold_addr",   addr_def, 32'h1010101F);
            chk("hold_sel",    {30'd0, sel_def}, 32'd1);
            chk("hold_rowadv", {31'd0, ra_def}, 32'd0);
            chk("hold_busy",   {31'd0, busy_def}, 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("rst_mid");

        // Run to MaxAddr=20: column 0 reaches it on enabled cycle 17.
        max_def = 8'd20;
        start   = 1'b1;
        step();
        start = 1'b0;
        on    = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            step();
            if (n == 16) begin
                chk("term_done_c16", {31'd0, done_def}, 32'd0);
                chk("term_busy_c16", {31'd0, busy_def}, 32'd1);
            end
        end
        chk("term_done",  {31'd0, done_def}, 32'd1);
        chk("term_busy",  {31'd0, busy_def}, 32'd0);
        chk("term_valid", {31'd0, av_def}, 32'd0);
        chk("term_addr",  addr_def, 32'h04040414);
        for (int n = 0; n < 4; n++) begin
            on = n[0];
            step();
            chk("done_addr", addr_def, 32'h04040414);
            chk("done_hold", {31'd0, done_def}, 32'd1);
        end

        // Restart from DONE reloads the window.
        start = 1'b1;
        step();
        chk("restart_addr", addr_def, 32'h0000000F);
        chk("restart_busy", {31'd0, busy_def}, 32'd1);
        chk("restart_done", {31'd0, done_def}, 32'd0);

        // Reset wins over Start and On in RUN; afterwards IDLE waits for Start.
        on  = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk_reset("rst_over");
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk_reset("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
